// File: rtl/draw_pkg.sv
// Shared constants and state encoding for the polyline sequencer and its draw path.
package draw_pkg;

    localparam int unsigned RGB_W   = 16;
    localparam int unsigned COORD_W = 16;

    // Word offsets of the x and y coordinates within a vertex record
    localparam logic VERT_X = 1'b0;
    localparam logic VERT_Y = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RD0X      = 4'd1,
        ST_RD0Y      = 4'd2,
        ST_SHIFT     = 4'd3,
        ST_RDX       = 4'd4,
        ST_RDY       = 4'd5,
        ST_ISSUE     = 4'd6,
        ST_WAIT_ACK  = 4'd7,
        ST_WAIT_DONE = 4'd8
    } state_t;

endpackage

// File: rtl/rise_edge_detect.sv
// Single-register rising-edge detector; rise_c is high while d=1 and the previous sample was 0.
module rise_edge_detect (
    input  logic clk,
    input  logic resn,
    input  logic d,
    output logic rise_c
);

    logic d_q;

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise_c = d & ~d_q;

endmodule

// File: rtl/polyline_sequencer.sv
// Walks a vertex list in the buffer RAM and issues one draw_line plot per segment of the polyline.
module polyline_sequencer
    import draw_pkg::*;
#(
    parameter int unsigned C_ADDR_BITS   = 10,
    parameter int unsigned C_LEN_BITS    = 9,
    parameter int unsigned C_ACK_TIMEOUT = 7
) (
    input  logic                   clk,
    input  logic                   resn,
    input  logic                   plot,
    input  logic [C_LEN_BITS-1:0]  len,
    input  logic [RGB_W-1:0]       color,
    output logic                   busy,
    output logic                   done,
    output logic                   buf_rd,
    output logic [C_ADDR_BITS-1:0] buf_addr,
    input  logic [COORD_W-1:0]     buf_data,
    output logic                   line_plot,
    input  logic                   line_busy,
    output logic [COORD_W-1:0]     line_x0,
    output logic [COORD_W-1:0]     line_y0,
    output logic [COORD_W-1:0]     line_x1,
    output logic [COORD_W-1:0]     line_y1,
    output logic [RGB_W-1:0]       line_color
);

    localparam int unsigned         CNT_W    = $clog2(C_ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    ACK_LAST = CNT_W'(C_ACK_TIMEOUT - 1);

    state_t                  state;
    logic                    rd_ph;
    logic [C_LEN_BITS-1:0]   len_q;
    logic [C_LEN_BITS-1:0]   idx;
    logic [CNT_W-1:0]        ack_cnt;
    logic                    plot_rise_c;
    logic                    last_seg_c;
    logic                    seg_end_c;

    rise_edge_detect u_plot_edge (
        .clk    (clk),
        .resn   (resn),
        .d      (plot),
        .rise_c (plot_rise_c)
    );

    function automatic logic [C_ADDR_BITS-1:0] vert_addr(input logic [C_LEN_BITS-1:0] v,
                                                         input logic word);
        return C_ADDR_BITS'({v, word});
    endfunction

    // A segment retires when draw_line goes idle, or when it never acknowledged the plot
    assign last_seg_c = (idx == len_q - C_LEN_BITS'(1));
    assign seg_end_c  = !line_busy &&
                        ((state == ST_WAIT_DONE) ||
                         ((state == ST_WAIT_ACK) && (ack_cnt == ACK_LAST)));

    // Each read state spends rd_ph=0 with buf_rd high and captures buf_data at the end of rd_ph=1
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state      <= ST_IDLE;
            rd_ph      <= 1'b0;
            len_q      <= '0;
            idx        <= '0;
            ack_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            buf_rd     <= 1'b0;
            buf_addr   <= '0;
            line_plot  <= 1'b0;
            line_x0    <= '0;
            line_y0    <= '0;
            line_x1    <= '0;
            line_y1    <= '0;
            line_color <= '0;
        end else begin
            done      <= 1'b0;
            line_plot <= 1'b0;
            buf_rd    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (plot_rise_c && (len >= C_LEN_BITS'(2))) begin
                        len_q      <= len;
                        line_color <= color;
                        busy       <= 1'b1;
                        rd_ph      <= 1'b0;
                        buf_rd     <= 1'b1;
                        buf_addr   <= vert_addr(C_LEN_BITS'(0), VERT_X);
                        state      <= ST_RD0X;
                    end
                end
                ST_RD0X: begin
                    rd_ph <= ~rd_ph;
                    if (rd_ph) begin
                        line_x1  <= buf_data;
                        buf_rd   <= 1'b1;
                        buf_addr <= vert_addr(C_LEN_BITS'(0), VERT_Y);
                        state    <= ST_RD0Y;
                    end
                end
                ST_RD0Y: begin
                    rd_ph <= ~rd_ph;
                    if (rd_ph) begin
                        line_y1 <= buf_data;
                        idx     <= C_LEN_BITS'(1);
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    line_x0  <= line_x1;
                    line_y0  <= line_y1;
                    buf_rd   <= 1'b1;
                    buf_addr <= vert_addr(idx, VERT_X);
                    state    <= ST_RDX;
                end
                ST_RDX: begin
                    rd_ph <= ~rd_ph;
                    if (rd_ph) begin
                        line_x1  <= buf_data;
                        buf_rd   <= 1'b1;
                        buf_addr <= vert_addr(idx, VERT_Y);
                        state    <= ST_RDY;
                    end
                end
                ST_RDY: begin
                    rd_ph <= ~rd_ph;
                    if (rd_ph) begin
                        line_y1 <= buf_data;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Hold off while draw_line is still busy with someone else's work
                    if (!line_busy) begin
                        line_plot <= 1'b1;
                        ack_cnt   <= '0;
                        state     <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (line_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (ack_cnt != ACK_LAST) begin
                        ack_cnt <= ack_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (seg_end_c) begin
                if (last_seg_c) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    idx   <= idx + C_LEN_BITS'(1);
                    state <= ST_SHIFT;
                end
            end
        end
    end

endmodule

// File: tb/tb_polyline_sequencer.sv
// Directed bench for polyline_sequencer with a buffer RAM model and a draw_line busy model.
module tb_polyline_sequencer;

    logic        clk;
    logic        resn;
    logic        plot;
    logic [8:0]  len;
    logic [15:0] color;
    logic        busy;
    logic        done;
    logic        buf_rd;
    logic [9:0]  buf_addr;
    logic [15:0] buf_data;
    logic        line_plot;
    logic        line_busy;
    logic [15:0] line_x0, line_y0, line_x1, line_y1, line_color;

    polyline_sequencer dut (
        .clk        (clk),
        .resn       (resn),
        .plot       (plot),
        .len        (len),
        .color      (color),
        .busy       (busy),
        .done       (done),
        .buf_rd     (buf_rd),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .line_plot  (line_plot),
        .line_busy  (line_busy),
        .line_x0    (line_x0),
        .line_y0    (line_y0),
        .line_x1    (line_x1),
        .line_y1    (line_y1),
        .line_color (line_color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer RAM: registered read, data valid the cycle after buf_rd
    logic [15:0] mem [0:1023];
    always @(posedge clk) if (buf_rd) buf_data <= mem[buf_addr];

    // draw_line model: busy for 50 cycles after each plot unless acknowledgement is suppressed
    int   busy_cnt = 0;
    logic ext_busy;
    logic no_ack_mode;
    always @(posedge clk) begin
        if (line_plot && !no_ack_mode) busy_cnt <= 50;
        else if (busy_cnt != 0)        busy_cnt <= busy_cnt - 1;
    end
    assign line_busy = (busy_cnt != 0) || ext_busy;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          plot_total = 0, done_total = 0, rd_total = 0, busy_total = 0, done_cyc = 0;
    logic [15:0] px0 [64], py0 [64], px1 [64], py1 [64], pcol [64];
    int          pcyc [64];

    always @(negedge clk) begin
        if (resn) begin
            if (line_plot) begin
                px0[plot_total % 64]  = line_x0;
                py0[plot_total % 64]  = line_y0;
                px1[plot_total % 64]  = line_x1;
                py1[plot_total % 64]  = line_y1;
                pcol[plot_total % 64] = line_color;
                pcyc[plot_total % 64] = cyc;
                plot_total++;
            end
            if (done) begin
                done_total++;
                done_cyc = cyc;
            end
            if (buf_rd) rd_total++;
            if (busy)   busy_total++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct packed {
        logic [8:0]        len;
        logic [15:0]       color;
        logic              no_ack;
        logic [2:0][15:0]  vx;
        logic [2:0][15:0]  vy;
        logic [7:0]        exp_plots;
        logic [7:0]        exp_reads;
        logic [7:0]        exp_done;
        logic              exp_busy;
        logic [7:0]        exp_gap;
    } vec_t;

    function automatic vec_t mk(input int l, input int c, input int na,
                                input int x0, input int y0, input int x1, input int y1,
                                input int x2, input int y2,
                                input int pl, input int rd, input int dn, input int bz, input int gap);
        vec_t v;
        v.len = 9'(l);   v.color = 16'(c);  v.no_ack = 1'(na);
        v.vx[0] = 16'(x0); v.vy[0] = 16'(y0);
        v.vx[1] = 16'(x1); v.vy[1] = 16'(y1);
        v.vx[2] = 16'(x2); v.vy[2] = 16'(y2);
        v.exp_plots = 8'(pl); v.exp_reads = 8'(rd); v.exp_done = 8'(dn);
        v.exp_busy = 1'(bz); v.exp_gap = 8'(gap);
        return v;
    endfunction

    task automatic load_vert(input int k, input logic [15:0] x, input logic [15:0] y);
        mem[2*k]   = x;
        mem[2*k+1] = y;
    endtask

    task automatic start_run(input logic [8:0] l, input logic [15:0] c, output int sc);
        @(negedge clk);
        len   = l;
        color = c;
        plot  = 1'b1;
        sc    = cyc + 1;
        repeat (3) @(negedge clk);
        plot  = 1'b0;
    endtask

    task automatic wait_done_since(input int base, input int limit);
        int k = 0;
        while (done_total <= base && k < limit) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_plots(input int target, input int limit);
        int k = 0;
        while (plot_total < target && k < limit) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_line_idle(input int limit);
        int k = 0;
        while (line_busy && k < limit) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       int'(busy),       0);
        check({tag, "_done"},       int'(done),       0);
        check({tag, "_buf_rd"},     int'(buf_rd),     0);
        check({tag, "_line_plot"},  int'(line_plot),  0);
        check({tag, "_buf_addr"},   int'(buf_addr),   0);
        check({tag, "_line_x0"},    int'(line_x0),    0);
        check({tag, "_line_y0"},    int'(line_y0),    0);
        check({tag, "_line_x1"},    int'(line_x1),    0);
        check({tag, "_line_y1"},    int'(line_y1),    0);
        check({tag, "_line_color"}, int'(line_color), 0);
    endtask

    // Hand-computed segments of the len=4 run: (1,2)->(3,4)->(5,6)->(7,8)
    int seg_a [3][4] = '{'{1, 2, 3, 4}, '{3, 4, 5, 6}, '{5, 6, 7, 8}};

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sc, rc, bp, bd, brd, bb, pi;
        vec_t v;

        resn = 1'b0; plot = 1'b0; len = '0; color = '0;
        ext_busy = 1'b0; no_ack_mode = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;

        // gap: plot-to-plot spacing; 58 = 1 + 50 busy + 1 sample + 6 overhead, 13 = 7 timeout + 6 overhead
        vecs[0] = mk(3, 16'hF800, 0, 10, 20, 100, 20, 100, 200, 2, 6, 1, 1, 58);
        vecs[1] = mk(1, 16'h07E0, 0, 1, 1, 2, 2, 3, 3,          0, 0, 0, 0, 0);
        vecs[2] = mk(0, 16'h07E0, 0, 1, 1, 2, 2, 3, 3,          0, 0, 0, 0, 0);
        vecs[3] = mk(2, 16'h07E0, 1, 5, 6, 7, 8, 0, 0,          1, 4, 1, 1, 0);
        vecs[4] = mk(2, 16'h1234, 0, 16'hFFFF, 0, 0, 16'hFFFF, 0, 0, 1, 4, 1, 1, 0);
        vecs[5] = mk(3, 16'hFFFF, 1, 0, 0, 16'hFFFF, 16'hFFFF, 1, 1, 2, 6, 1, 1, 13);

        #12;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        resn = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            v = vecs[r];
            for (int k = 0; k < 3; k++) load_vert(k, v.vx[k], v.vy[k]);
            no_ack_mode = v.no_ack;
            bp = plot_total; bd = done_total; brd = rd_total; bb = busy_total;
            start_run(v.len, v.color, sc);
            if (v.len >= 9'd2) wait_done_since(bd, 1000);
            else repeat (30) @(negedge clk);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_plots", r), plot_total - bp, int'(v.exp_plots));
            check($sformatf("v%0d_reads", r), rd_total - brd, int'(v.exp_reads));
            check($sformatf("v%0d_done", r), done_total - bd, int'(v.exp_done));
            check($sformatf("v%0d_busy_seen", r), int'(busy_total > bb), int'(v.exp_busy));
            check($sformatf("v%0d_busy_end", r), int'(busy), 0);
            for (int j = 0; j < int'(v.exp_plots); j++) begin
                pi = (bp + j) % 64;
                check($sformatf("v%0d_s%0d_x0", r, j), int'(px0[pi]), int'(v.vx[j]));
                check($sformatf("v%0d_s%0d_y0", r, j), int'(py0[pi]), int'(v.vy[j]));
                check($sformatf("v%0d_s%0d_x1", r, j), int'(px1[pi]), int'(v.vx[j+1]));
                check($sformatf("v%0d_s%0d_y1", r, j), int'(py1[pi]), int'(v.vy[j+1]));
                check($sformatf("v%0d_s%0d_color", r, j), int'(pcol[pi]), int'(v.color));
            end
            if (v.exp_plots > 0)
                check($sformatf("v%0d_first_latency", r), pcyc[bp % 64] - sc, 10);
            if (v.exp_plots == 2)
                check($sformatf("v%0d_seg_gap", r), pcyc[(bp + 1) % 64] - pcyc[bp % 64], int'(v.exp_gap));
            if (v.no_ack && v.exp_done > 0)
                check($sformatf("v%0d_ack_timeout", r),
                      done_cyc - pcyc[(bp + int'(v.exp_plots) - 1) % 64], 7);
            wait_line_idle(200);
        end
        no_ack_mode = 1'b0;

        // len=4 with a second start edge, colour and len changes mid-run
        load_vert(0, 1, 2); load_vert(1, 3, 4); load_vert(2, 5, 6); load_vert(3, 7, 8);
        bp = plot_total; bd = done_total; brd = rd_total;
        start_run(9'd4, 16'hAAAA, sc);
        wait_plots(bp + 1, 200);
        @(negedge clk);
        color = 16'h001F; len = 9'd2; plot = 1'b1;
        repeat (2) @(negedge clk);
        plot = 1'b0;
        wait_done_since(bd, 2000);
        repeat (30) @(negedge clk);
        check("midrun_plots", plot_total - bp, 3);
        check("midrun_done", done_total - bd, 1);
        check("midrun_reads", rd_total - brd, 8);
        check("midrun_busy_end", int'(busy), 0);
        for (int j = 0; j < 3; j++) begin
            pi = (bp + j) % 64;
            check($sformatf("midrun_s%0d_x0", j), int'(px0[pi]), seg_a[j][0]);
            check($sformatf("midrun_s%0d_y0", j), int'(py0[pi]), seg_a[j][1]);
            check($sformatf("midrun_s%0d_x1", j), int'(px1[pi]), seg_a[j][2]);
            check($sformatf("midrun_s%0d_y1", j), int'(py1[pi]), seg_a[j][3]);
            check($sformatf("midrun_s%0d_color", j), int'(pcol[pi]), 16'hAAAA);
        end
        wait_line_idle(200);

        // Reset during WAIT_DONE of segment 2, then a fresh start
        load_vert(0, 10, 10); load_vert(1, 20, 10); load_vert(2, 20, 30);
        bp = plot_total; bd = done_total;
        start_run(9'd3, 16'h1111, sc);
        wait_plots(bp + 2, 300);
        repeat (10) @(negedge clk);
        #2 resn = 1'b0;
        #1 check_all_zero("rst_mid");
        repeat (3) @(negedge clk);
        resn = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_mid_no_done", done_total - bd, 0);
        wait_line_idle(200);
        bp = plot_total; bd = done_total;
        start_run(9'd2, 16'h2222, sc);
        wait_done_since(bd, 500);
        repeat (2) @(negedge clk);
        check("rst_fresh_plots", plot_total - bp, 1);
        check("rst_fresh_done", done_total - bd, 1);
        check("rst_fresh_x0", int'(px0[bp % 64]), 10);
        check("rst_fresh_y0", int'(py0[bp % 64]), 10);
        check("rst_fresh_x1", int'(px1[bp % 64]), 20);
        check("rst_fresh_y1", int'(py1[bp % 64]), 10);
        check("rst_fresh_color", int'(pcol[bp % 64]), 16'h2222);
        check("rst_fresh_latency", pcyc[bp % 64] - sc, 10);
        wait_line_idle(200);

        // draw_line already busy when ISSUE is reached
        load_vert(0, 300, 400); load_vert(1, 500, 600);
        @(negedge clk);
        ext_busy = 1'b1;
        bp = plot_total; bd = done_total;
        start_run(9'd2, 16'h0F0F, sc);
        repeat (25) @(negedge clk);
        check("hold_no_plot", plot_total - bp, 0);
        check("hold_busy", int'(busy), 1);
        @(negedge clk);
        ext_busy = 1'b0;
        rc = cyc + 1;
        wait_done_since(bd, 300);
        repeat (2) @(negedge clk);
        check("hold_plots", plot_total - bp, 1);
        check("hold_plot_cycle", pcyc[bp % 64], rc);
        check("hold_x0", int'(px0[bp % 64]), 300);
        check("hold_y0", int'(py0[bp % 64]), 400);
        check("hold_x1", int'(px1[bp % 64]), 500);
        check("hold_y1", int'(py1[bp % 64]), 600);
        check("hold_color", int'(pcol[bp % 64]), 16'h0F0F);
        check("hold_done", done_total - bd, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/polyline_sequencer.md
Name: polyline_sequencer

Overview:
Sequences the draw_line engine through a list of vertices held in a buffer RAM written over the ESP32 SPI slave. One start pulse draws a connected polyline v0→v1→…→v(len-1) in a single colour. It issues one draw_line plot per segment and waits for draw_line busy before fetching the next vertex. It sits between the SPI register/RAM block and draw_line, which in turn feeds lcd_hvline.

Parameters:
C_ADDR_BITS, 10, vertex buffer word-address width (16-bit words)
C_LEN_BITS, 9, width of vertex count; max vertices = 2^C_LEN_BITS-1, must satisfy 2*max ≤ 2^C_ADDR_BITS
C_ACK_TIMEOUT, 7, cycles to wait for line_busy to rise after line_plot before treating the segment as finished

Ports:
clk  in  1  system clock (100 MHz PLL output)
resn  in  1  asynchronous active-low reset
plot  in  1  start request; acts on rising edge
len  in  C_LEN_BITS  number of vertices, sampled at start
color  in  16  RGB565 colour, sampled at start
busy  out  1  high from accepted start until the last segment completes
done  out  1  one-cycle pulse when the polyline finishes
buf_rd  out  1  vertex buffer read strobe
buf_addr  out  C_ADDR_BITS  vertex buffer word address
buf_data  in  16  vertex buffer read data, valid the cycle after buf_rd
line_plot  out  1  one-cycle start pulse to draw_line
line_busy  in  1  draw_line busy
line_x0, line_y0, line_x1, line_y1  out  16 each  segment endpoints, stable from line_plot until the segment completes
line_color  out  16  latched colour

Behaviour:
- Reset (resn=0, asynchronous): state IDLE; busy, done, buf_rd, line_plot = 0; buf_addr, all line_* = 0; plot edge detector register = 0.
- Buffer layout: vertex k has x at word 2k and y at word 2k+1. Coordinates are used as-is, 16 bit, no clipping.
- Start: plot rising edge (plot=1 and previous plot=0) in IDLE with len ≥ 2 latches len and color and asserts busy on the next cycle. If len < 2, the edge is ignored: busy stays 0 and no done pulse. Edges while busy are ignored and are not queued.
- States:
  - IDLE
  - RD0X, RD0Y: read v0 into x1/y1
  - SHIFT: x0←x1, y0←y1
  - RDX, RDY: read the next vertex into x1/y1
  - ISSUE: one-cycle line_plot
  - WAIT_ACK
  - WAIT_DONE
- Reads: buf_rd and buf_addr are driven in cycle N; buf_data is captured in N+1. Each read state therefore takes 2 cycles (issue, capture). Reads are never overlapped.
- Segment loop: after RD0X/RD0Y go to SHIFT, then RDX/RDY for vertex index i (starting at i=1), then ISSUE.
- WAIT_ACK: waits for line_busy=1, then moves to WAIT_DONE. If line_busy stays 0 for C_ACK_TIMEOUT cycles, it treats the segment as complete.
- WAIT_DONE: waits for line_busy=0.
- On completion: if i == len-1, go to IDLE, pulse done and drop busy in the same cycle. Otherwise i←i+1 and go to SHIFT.
- Each vertex is read exactly once, so buffer traffic is 2·len reads per polyline.
- Latency from start edge to first line_plot: 1 + 4 reads × 2 + 1 shift = 10 cycles, fixed. Inter-segment overhead after draw_line finishes is 6 cycles (SHIFT + 2 reads + ISSUE).
- line_color is held at the start-time colour for the whole polyline. Changes on the color or len inputs mid-run have no effect.
- If line_busy is already 1 on entering ISSUE (draw_line not idle), the block holds in ISSUE with line_plot=0 until line_busy=0, then pulses.
- Reset mid-operation aborts immediately with no done pulse. draw_line may still finish its current segment on its own.

Decomposition:
- Shared package (draw_pkg): state encoding localparams, RGB565 width constant (16), coordinate width constant (16), vertex word-offset constants (X=0, Y=1).
- One natural sub-module: rise_edge_detect (single-register rising-edge detector on plot). All other logic stays in one always block plus output registers.

Test Plan:
- len=3, buffer = (10,20),(100,20),(100,200), color=16'hF800; line_busy model high for 50 cycles after each plot → two plots with endpoints (10,20)-(100,20) then (100,20)-(100,200), line_color=F800 throughout, first plot 10 cycles after the edge, one done pulse, 6 buf_rd total.
- len=1 and len=0 start edges → no buf_rd, no line_plot, busy and done stay 0.
- draw_line model that never raises line_busy, len=2 → one line_plot, segment retired after C_ACK_TIMEOUT=7 cycles, done pulse follows, no hang.
- Second plot edge and a color change to 16'h001F during a len=4 run → ignored; exactly 3 segments, all in the original colour, single done pulse.
- resn asserted during WAIT_DONE of segment 2 → all outputs 0 asynchronously, no done pulse. A fresh start after release draws from v0 correctly.
- line_busy already 1 when ISSUE is reached → line_plot held off until line_busy falls, then exactly one pulse with correct endpoints.
